// File: rtl/npu_fc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : npu_fc_pkg
// Description : Shared constants, sample/accumulator types and flattener
//               state encoding for the fully-connected layer input path.
// Revision    : 1.0 - initial release
// ============================================================================
package npu_fc_pkg;

    localparam int N_ELEM = 225;
    localparam int DATA_W = 22;
    localparam int ACC_W  = 48;
    localparam int PTR_W  = $clog2(N_ELEM);

    typedef logic signed [DATA_W-1:0] feat_t;
    typedef logic signed [ACC_W-1:0]  acc_t;
    typedef logic [PTR_W-1:0]         ptr_t;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } flat_state_t;

    function automatic logic is_last_idx(input ptr_t p);
        return p == PTR_W'(N_ELEM - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rise_detect.sv
`default_nettype none
// ============================================================================
// Module      : rise_detect
// Description : Rising-edge detector against a registered previous value.
// Revision    : 1.0 - initial release
// ============================================================================
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_sig,
    output logic o_rise
);

    logic r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_sig;
        end
    end

    assign o_rise = i_sig & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/fc_input_flattener.sv
`default_nettype none
// ============================================================================
// Module      : fc_input_flattener
// Description : Collects a raster frame of pooled samples into a flat array,
//               launches the FC layer with a level start and captures its
//               result as a one-cycle pulse. Optional macro
//               FLATTEN_DROP_CNT_EN enables the saturating drop counter.
// Revision    : 1.0 - initial release
// ============================================================================
module fc_input_flattener
    import npu_fc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    input  logic        i_sof,
    input  feat_t       i_data,
    output logic        o_ready,
    output feat_t       o_flattened_data [0:N_ELEM-1],
    output logic        o_start,
    input  logic        i_fc_result_valid,
    input  acc_t        i_fc_result_data,
    output logic        o_result_valid,
    output acc_t        o_result_data,
    output logic        o_sync_err,
    output logic [15:0] o_drop_cnt
);

    flat_state_t r_state;
    ptr_t        r_wr_ptr;
    feat_t       r_buf [0:N_ELEM-1];
    logic        r_ready;
    logic        r_start;
    logic        r_result_valid;
    acc_t        r_result_data;
    logic        r_sync_err;

    logic        w_fc_rise;
    logic        w_wr_en;
    ptr_t        w_wr_idx;

    rise_detect u_rise_detect (
        .clk    (clk),
        .rst    (rst),
        .i_sig  (i_fc_result_valid),
        .o_rise (w_fc_rise)
    );

    // A start-of-frame sample always lands at index 0, whatever the pointer.
    assign w_wr_en  = (r_state == FILL) && i_valid;
    assign w_wr_idx = i_sof ? '0 : r_wr_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_ELEM; i++) begin
                r_buf[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_buf[w_wr_idx] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= FILL;
            r_wr_ptr       <= '0;
            r_ready        <= 1'b1;
            r_start        <= 1'b0;
            r_result_valid <= 1'b0;
            r_result_data  <= '0;
            r_sync_err     <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            r_sync_err     <= 1'b0;
            case (r_state)
                FILL: begin
                    if (i_valid) begin
                        if (i_sof) begin
                            r_wr_ptr   <= PTR_W'(1);
                            r_sync_err <= (r_wr_ptr != '0);
                        end else if (is_last_idx(r_wr_ptr)) begin
                            r_wr_ptr <= '0;
                            r_ready  <= 1'b0;
                            r_start  <= 1'b1;
                            r_state  <= WAIT;
                        end else begin
                            r_wr_ptr <= r_wr_ptr + 1'b1;
                        end
                    end
                end
                WAIT: begin
                    // A valid already high on entry is a stale window, not an edge.
                    if (w_fc_rise) begin
                        r_result_data  <= i_fc_result_data;
                        r_result_valid <= 1'b1;
                        r_start        <= 1'b0;
                        r_state        <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!i_fc_result_valid) begin
                        r_ready <= 1'b1;
                        r_state <= FILL;
                    end
                end
                default: begin
                    r_state <= FILL;
                    r_ready <= 1'b1;
                    r_start <= 1'b0;
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < N_ELEM; gi++) begin : g_flat
            assign o_flattened_data[gi] = r_buf[gi];
        end
    endgenerate

`ifdef FLATTEN_DROP_CNT_EN
    logic [15:0] r_drop_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (i_valid && !r_ready && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign o_drop_cnt = r_drop_cnt;
`else
    assign o_drop_cnt = 16'd0;
`endif

    assign o_ready        = r_ready;
    assign o_start        = r_start;
    assign o_result_valid = r_result_valid;
    assign o_result_data  = r_result_data;
    assign o_sync_err     = r_sync_err;

endmodule
`default_nettype wire

// File: tb/tb_fc_input_flattener.sv
`default_nettype none
// ============================================================================
// Module      : tb_fc_input_flattener
// Description : Scoreboard bench for fc_input_flattener with a queue-based
//               frame model and a decoupled result monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fc_input_flattener;
    import npu_fc_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        i_sof = 1'b0;
    feat_t       i_data = '0;
    logic        i_fc_result_valid = 1'b0;
    acc_t        i_fc_result_data = '0;
    logic        o_ready;
    feat_t       o_flattened_data [0:N_ELEM-1];
    logic        o_start;
    logic        o_result_valid;
    acc_t        o_result_data;
    logic        o_sync_err;
    logic [15:0] o_drop_cnt;

    int    n_checks   = 0;
    int    n_errors   = 0;
    int    n_pulses   = 0;
    int    exp_pulses = 0;
    int    exp_drops  = 0;
    logic  m_ready    = 1'b1;
    feat_t frame_q [$];
    feat_t exp_buf [0:N_ELEM-1];
    acc_t  sb_q [$];
    acc_t  mon_exp;

    fc_input_flattener dut (
        .clk               (clk),
        .rst               (rst),
        .i_valid           (i_valid),
        .i_sof             (i_sof),
        .i_data            (i_data),
        .o_ready           (o_ready),
        .o_flattened_data  (o_flattened_data),
        .o_start           (o_start),
        .i_fc_result_valid (i_fc_result_valid),
        .i_fc_result_data  (i_fc_result_data),
        .o_result_valid    (o_result_valid),
        .o_result_data     (o_result_data),
        .o_sync_err        (o_sync_err),
        .o_drop_cnt        (o_drop_cnt)
    );

    always #5 clk = ~clk;

    // Result monitor: every pulse must match the oldest outstanding FC result.
    always @(negedge clk) begin
        if (!rst && o_result_valid) begin
            n_pulses++;
            n_checks++;
            if (sb_q.size() == 0) begin
                n_errors++;
                $display("FAIL result_unexpected: got pulse with %h, required no pulse", o_result_data);
            end else begin
                mon_exp = sb_q.pop_front();
                if (o_result_data !== mon_exp) begin
                    n_errors++;
                    $display("FAIL result_data: got %h, required %h", o_result_data, mon_exp);
                end
            end
        end
    end

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic check_buf(input string name);
        int bad;
        bad = -1;
        for (int i = 0; i < N_ELEM; i++) begin
            if (bad < 0 && o_flattened_data[i] !== exp_buf[i]) bad = i;
        end
        n_checks++;
        if (bad >= 0) begin
            n_errors++;
            $display("FAIL %s: element %0d got %0d, required %0d", name, bad, o_flattened_data[bad], exp_buf[bad]);
        end
    endtask

    task automatic tick();
        if (i_valid && !m_ready) begin
`ifdef FLATTEN_DROP_CNT_EN
            if (exp_drops < 65535) exp_drops++;
`endif
        end
        @(posedge clk);
        #1;
    endtask

    // Frame model: sof restarts the frame; a frame of N_ELEM samples launches.
    task automatic send_sample(input feat_t d, input logic sof, input string tag);
        logic resync;
        logic launch;
        resync = sof && (frame_q.size() != 0);
        if (sof) frame_q.delete();
        frame_q.push_back(d);
        launch = (frame_q.size() == N_ELEM);
        i_valid = 1'b1;
        i_sof   = sof;
        i_data  = d;
        tick();
        i_valid = 1'b0;
        i_sof   = 1'b0;
        check({tag, "_sync_err"}, o_sync_err, resync);
        check({tag, "_start"}, o_start, launch);
        check({tag, "_ready"}, o_ready, !launch);
        if (launch) begin
            for (int i = 0; i < N_ELEM; i++) exp_buf[i] = frame_q[i];
            frame_q.delete();
            m_ready = 1'b0;
            check_buf({tag, "_buf"});
        end
    endtask

    task automatic send_frame(input int n, input bit sof_first, input bit gaps, input string tag);
        for (int k = 0; k < n; k++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                tick();
                check({tag, "_gap_start"}, o_start, 0);
            end
            send_sample(feat_t'($urandom), sof_first && (k == 0), tag);
        end
    endtask

    task automatic fc_return(input acc_t data, input int latency, input int hold, input bit noise, input string tag);
        for (int k = 0; k < latency; k++) begin
            i_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
        end
        i_valid = 1'b0;
        check({tag, "_start_held"}, o_start, 1);
        sb_q.push_back(data);
        exp_pulses++;
        i_fc_result_data  = data;
        i_fc_result_valid = 1'b1;
        tick();
        check({tag, "_rv_pulse"}, o_result_valid, 1);
        check({tag, "_start_fall"}, o_start, 0);
        check({tag, "_ready_drain"}, o_ready, 0);
        for (int k = 1; k < hold; k++) begin
            tick();
            check({tag, "_rv_single"}, o_result_valid, 0);
            check({tag, "_ready_hold"}, o_ready, 0);
        end
        i_fc_result_valid = 1'b0;
        i_fc_result_data  = acc_t'({$urandom, $urandom});
        tick();
        m_ready = 1'b1;
        check({tag, "_ready_back"}, o_ready, 1);
        check_buf({tag, "_buf_frozen"});
        check({tag, "_drop_cnt"}, o_drop_cnt, exp_drops);
    endtask

    initial begin
        for (int i = 0; i < N_ELEM; i++) exp_buf[i] = '0;
        rst = 1'b1;
        tick();
        tick();
        check("rst_ready", o_ready, 1);
        check("rst_start", o_start, 0);
        check("rst_result_valid", o_result_valid, 0);
        check("rst_result_data", o_result_data, 0);
        check("rst_sync_err", o_sync_err, 0);
        check("rst_drop_cnt", o_drop_cnt, 0);
        check_buf("rst_buf");
        rst = 1'b0;
        tick();

        // Full frame of index-100 values, then the FC result with drop noise.
        for (int k = 0; k < N_ELEM; k++) send_sample(feat_t'(k - 100), k == 0, "full");
        check("full_flat0", o_flattened_data[0], -100);
        check("full_flat224", o_flattened_data[N_ELEM-1], 124);
        fc_return(48'sh0000_0001_2345, 230, 17, 1'b1, "ret");

        // Resync after 100 samples; valid goes high before launch (stale).
        send_frame(100, 1'b1, 1'b0, "pre");
        send_sample(feat_t'(7), 1'b1, "resync");
        check("resync_buf0", o_flattened_data[0], 7);
        for (int k = 1; k < N_ELEM; k++) begin
            if (k == 200) i_fc_result_valid = 1'b1;
            send_sample(feat_t'($urandom), 1'b0, "post");
        end
        for (int k = 0; k < 10; k++) begin
            tick();
            check("stale_start", o_start, 1);
            check("stale_ready", o_ready, 0);
        end
        i_fc_result_valid = 1'b0;
        repeat (3) tick();
        fc_return(acc_t'({$urandom, $urandom}), 0, 5, 1'b0, "stale");

        // Randomised frames with gaps, latencies and hold windows.
        for (int f = 0; f < 2; f++) begin
            send_frame(N_ELEM, 1'b1, 1'b1, "rnd");
            fc_return(acc_t'({$urandom, $urandom}), int'($urandom_range(1, 300)),
                      int'($urandom_range(1, 20)), 1'b1, "rnd");
        end

        // Reset while waiting for the FC result.
        send_frame(N_ELEM, 1'b1, 1'b0, "rstf");
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        frame_q.delete();
        m_ready   = 1'b1;
        exp_drops = 0;
        for (int i = 0; i < N_ELEM; i++) exp_buf[i] = '0;
        check("midrst_start", o_start, 0);
        check("midrst_ready", o_ready, 1);
        check("midrst_result_valid", o_result_valid, 0);
        check("midrst_drop_cnt", o_drop_cnt, 0);
        check_buf("midrst_buf");
        send_sample(feat_t'(-5), 1'b0, "after_rst");
        check("after_rst_idx0", o_flattened_data[0], -5);

        // Long drop burst while waiting.
        send_frame(N_ELEM, 1'b1, 1'b0, "sat");
        i_valid = 1'b1;
        repeat (70000) tick();
        i_valid = 1'b0;
`ifdef FLATTEN_DROP_CNT_EN
        check("drop_sat", o_drop_cnt, 65535);
`else
        check("drop_sat", o_drop_cnt, 0);
`endif
        check_buf("sat_buf_frozen");
        fc_return(acc_t'({$urandom, $urandom}), 2, 3, 1'b0, "final");

        repeat (3) tick();
        check("sb_empty", sb_q.size(), 0);
        check("pulse_count", n_pulses, exp_pulses);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
